// File: rtl/bcd_scan_mux_if.sv
// Scan-mux bus: latched BCD digits and control in, selected digit/anode out.
// Ports: digits_in, load, enable, blank_lz -> digito, anodo, blank, scan_idx, frame_done.
interface bcd_scan_mux_if #(
  parameter int N_DIGITS = 8
);
  localparam int IW = $clog2(N_DIGITS);

  logic [4*N_DIGITS-1:0] digits_in;
  logic                  load;
  logic                  enable;
  logic                  blank_lz;
  logic [3:0]            digito;
  logic [N_DIGITS-1:0]   anodo;
  logic                  blank;
  logic [IW-1:0]         scan_idx;
  logic                  frame_done;

  modport master (
    output digits_in, load, enable, blank_lz,
    input  digito, anodo, blank, scan_idx, frame_done
  );

  modport slave (
    input  digits_in, load, enable, blank_lz,
    output digito, anodo, blank, scan_idx, frame_done
  );
endinterface

// File: rtl/bcd_scan_mux.sv
// Time-multiplexed scan controller for an N-digit common-anode 7-seg display.
// Ports: clk, rst_n (async active-low), bus (slave side of bcd_scan_mux_if).
module bcd_scan_mux #(
  parameter  int N_DIGITS    = 8,
  parameter  int REFRESH_DIV = 100000,
  localparam int CW          = $clog2(REFRESH_DIV)
) (
  input  logic           clk,
  input  logic           rst_n,
  bcd_scan_mux_if.slave  bus
);
  localparam int IW = $clog2(N_DIGITS);
  localparam int DW = 4 * N_DIGITS;
  localparam logic [CW-1:0] DIV_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(N_DIGITS - 1);

  logic [CW-1:0]       div_cnt;
  logic [IW-1:0]       scan_idx;
  logic [DW-1:0]       shadow;
  logic [DW-1:0]       disp;
  logic                pending;
  logic                tick;
  logic                wrap;
  logic [N_DIGITS-1:0] lz;
  logic                zrun;

  logic [3:0]          digito;
  logic [N_DIGITS-1:0] anodo;
  logic                blank;
  logic                frame_done;

  assign tick = bus.enable && (div_cnt == DIV_MAX);
  assign wrap = tick && (scan_idx == IDX_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt    <= '0;
      scan_idx   <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= wrap;
      if (bus.enable) begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
        if (tick)
          scan_idx <= (scan_idx == IDX_MAX) ? '0 : scan_idx + 1'b1;
      end
    end
  end

  // disp only moves at a frame boundary so a frame never mixes two values;
  // a load landing on the wrap cycle bypasses the shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow  <= '0;
      disp    <= '0;
      pending <= 1'b0;
    end else if (wrap) begin
      pending <= 1'b0;
      if (bus.load)
        disp <= bus.digits_in;
      else if (pending)
        disp <= shadow;
    end else if (bus.load) begin
      shadow  <= bus.digits_in;
      pending <= 1'b1;
    end
  end

  // Walk from the MSD down; a digit is a leading zero while every digit
  // above it (and itself) is zero. Digit 0 always shows.
  always_comb begin
    lz   = '0;
    zrun = bus.blank_lz;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      zrun = zrun && (disp[4*i +: 4] == 4'd0);
      if (i != 0)
        lz[i] = zrun;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digito <= 4'd0;
      anodo  <= '1;
      blank  <= 1'b1;
    end else begin
      digito <= disp[4*scan_idx +: 4];
      anodo  <= bus.enable ? ~(N_DIGITS'(1) << scan_idx) : '1;
      blank  <= ~bus.enable | lz[scan_idx];
    end
  end

  assign bus.digito     = digito;
  assign bus.anodo      = anodo;
  assign bus.blank      = blank;
  assign bus.scan_idx   = scan_idx;
  assign bus.frame_done = frame_done;
endmodule

// File: doc/bcd_scan_mux.md
Name: bcd_scan_mux

Overview:
- Time-multiplexed scan controller for an N-digit common-anode 7-segment display.
- Latches a packed vector of BCD digits and rotates through the digits at a divided refresh rate.
- Presents the selected 4-bit BCD digit to the downstream BCD-to-segment decoder, together with an active-low anode select and a blank flag.
- Sits between the number-conversion datapath (binary/Gray-to-BCD) and the segment decoder.

Parameters:
N_DIGITS, 8, number of display digits (2..8)
REFRESH_DIV, 100000, clk cycles per digit slot (>=2); 100 MHz gives a 1 kHz digit rate
CW, $clog2(REFRESH_DIV), divider counter width (derived, not overridden)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
digits_in  input  4*N_DIGITS  packed BCD; [3:0] = digit 0 (rightmost), [4*N_DIGITS-1 -: 4] = MSD
load  input  1  single-cycle strobe; captures digits_in
enable  input  1  1 = scan and drive anodes; 0 = display dark, counters frozen
blank_lz  input  1  1 = suppress leading zeros
digito  output  4  BCD digit for current slot, to segment decoder
anodo  output  N_DIGITS  active-low anode enables, one-hot-low when lit
blank  output  1  1 = current slot must be dark; decoder output is forced to all ones downstream
scan_idx  output  $clog2(N_DIGITS)  index of current slot
frame_done  output  1  one-cycle pulse when scan_idx wraps N_DIGITS-1 -> 0

Behaviour:
- Reset (async assert, sync release): div_cnt=0, scan_idx=0, shadow=0, disp=0, pending=0, digito=0, anodo=all ones, blank=1, frame_done=0.
- Divider:
  - When enable=1: div_cnt counts 0..REFRESH_DIV-1. tick=1 in the cycle div_cnt==REFRESH_DIV-1; div_cnt then returns to 0.
  - When enable=0: div_cnt and scan_idx hold.
- Scan:
  - On tick, scan_idx <= (scan_idx==N_DIGITS-1) ? 0 : scan_idx+1.
  - wrap = tick && scan_idx==N_DIGITS-1.
  - frame_done <= wrap, so it is high for the one cycle after wrap.
- Load / tear-free update:
  - load=1 and not wrap: shadow <= digits_in, pending <= 1. Latest load wins; disp is unchanged.
  - wrap and load=1: disp <= digits_in directly, pending <= 0.
  - wrap, load=0 and pending=1: disp <= shadow, pending <= 0.
  - disp therefore changes only at a frame boundary. digits_in is not used outside load cycles.
- Leading-zero blanking:
  - lz[i]=1 when blank_lz=1, i!=0, and disp digits N_DIGITS-1..i are all 4'd0.
  - Digit 0 is never blanked, so the all-zero value shows a single "0".
- Output register: one cycle after scan_idx, disp, enable or blank_lz change:
  - digito <= disp[4*scan_idx +: 4]
  - anodo <= enable ? ~(1<<scan_idx) : all ones
  - blank <= ~enable | lz[scan_idx]
- Non-BCD nibbles (10..15) pass to digito unchanged. The decoder maps them to "0". No error flag.
- Exactly one anodo bit is low while enable=1; no bits are low while enable=0 or in reset.
- Reset mid-frame: all state clears immediately. Any pending load is lost.
- enable deassert mid-slot: anodo goes all ones in the next cycle. On reassert, scanning resumes from the frozen div_cnt and scan_idx.

Test Plan:
- Reset and first slot (N_DIGITS=4, REFRESH_DIV=4): hold rst_n=0 -> anodo=4'b1111, blank=1, digito=0. Release with enable=1 -> next cycle anodo=4'b1110, blank=0.
- Scan order: load 16'h4321, run 2 frames -> after the first wrap, digito sequence is 1,2,3,4 with anodo 1110,1101,1011,0111, each held 4 cycles. frame_done pulses once per 16 cycles.
- Tear-free load: load 16'h9876 mid-frame while showing 4321 -> remaining slots still show 3,4. After the wrap they show 6,7,8,9. pending clears at the wrap.
- Load at wrap and back-to-back loads: load 16'h1111 then 16'h2222 before the wrap -> 2222 is displayed. A load of 16'h5555 in the exact wrap cycle -> 5555 is displayed from slot 0 of the new frame.
- Leading zeros: disp=16'h0050, blank_lz=1 -> blank=1,1,0,0 for slots 3,2,1,0. disp=16'h0000 -> only slot 0 is unblanked, digito=0. With blank_lz=0, nothing is blanked.
- Enable gating and async reset: enable=0 for 10 cycles mid-slot 2 -> anodo=4'b1111, blank=1, scan_idx=2 held; on re-enable, slot 2 finishes its remaining cycles. rst_n low mid-frame with a pending load -> outputs are at reset values in the same cycle, and after release disp=0.
